mc_control_unit_v2: RTL
=======================

Name: mc_control_unit_v2

Overview:
Parametrised multi-cycle control FSM that replaces the fixed control unit behind the datapath. Adds:
- memory ready handshake with wait states and a timeout counter
- explicit instruction fetch and IR-load strobes
- illegal-opcode detection, a HALT state and a retired-instruction counter

Sits beside the datapath in the microcontroller top. It receives the opcode and zero flag and drives all datapath control strobes.

Parameters:
OPCODE_W, 5, opcode width; opcodes below are zero-extended to this width
ALU_CTRL_W, 5, alu_control width; codes zero-extended
MEM_TIMEOUT, 16, max wait cycles with mem_ready low before bus error; 0 disables the timeout
CNT_W, 16, width of instr_count

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
opcode  in  OPCODE_W  opcode field of the current IR
zero_flag  in  1  ALU zero result
mem_ready  in  1  memory completes the current fetch/read/write this cycle
inst_read  out  1  instruction fetch request
ir_write  out  1  load IR
pc_write  out  1  update PC
pc_source  out  2  00 PC+1, 01 branch target, 10 jump target, 11 IRQ vector
mem_read  out  1  data read request
mem_write  out  1  data write request
reg_write  out  1  register file write
alu_src_b  out  1  0 register, 1 immediate
reg_dst  out  2  00 rt, 01 rd, 10 link register
mem_to_reg  out  2  00 ALU, 01 memory, 10 PC (link)
alu_control  out  ALU_CTRL_W  ADD=0, SUB=1, AND=2, OR=3, XOR=4
halted  out  1  high in HALT
bus_error  out  1  sticky timeout flag
illegal_op  out  1  one-cycle pulse on undefined opcode
instr_count  out  CNT_W  retired instruction count

Behaviour:
- Opcodes: 00 NOP, 01 ADD, 02 SUB, 03 AND, 04 OR, 05 XOR, 06 ADDI, 07 LW, 08 SW, 09 BEQ, 0A BNE, 0B JMP, 0C JAL, 1F HLT. All others are illegal.
- Outputs are decoded from the registered state; ir_write and pc_write in FETCH are additionally qualified by mem_ready. Any output not listed for a state is 0.
- Reset (rst low): state S_RESET, all outputs 0, instr_count 0, bus_error 0, wait counter 0. Asserting reset mid-instruction aborts immediately. The first edge after release moves to S_FETCH.
- S_FETCH: inst_read=1. When mem_ready=1, in the same cycle: ir_write=1, pc_write=1, pc_source=00; next state S_DECODE.
- S_DECODE (1 cycle), dispatch on opcode:
  - R-type -> S_EXEC_R; ADDI -> S_EXEC_I; LW/SW -> S_ADDR; BEQ/BNE -> S_BR; JMP/JAL -> S_JMP; HLT -> S_HALT.
  - NOP -> S_FETCH, retired.
  - Illegal -> illegal_op=1 for this cycle, -> S_FETCH, not retired.
- S_EXEC_R: alu_src_b=0, alu_control per opcode -> S_WB_R: reg_write=1, reg_dst=01, mem_to_reg=00 -> S_FETCH.
- S_EXEC_I: alu_src_b=1, ADD -> S_WB_I: reg_write=1, reg_dst=00, mem_to_reg=00 -> S_FETCH.
- S_ADDR: alu_src_b=1, ADD. Next state S_MEM_RD for LW, S_MEM_WR for SW.
- S_MEM_RD: mem_read=1, held until mem_ready -> S_WB_LD: reg_write=1, reg_dst=00, mem_to_reg=01 -> S_FETCH.
- S_MEM_WR: mem_write=1, held until mem_ready -> S_FETCH.
- S_BR: alu_src_b=0, SUB, pc_source=01. pc_write=zero_flag for BEQ, ~zero_flag for BNE -> S_FETCH.
- S_JMP: pc_write=1, pc_source=10. For JAL also reg_write=1, reg_dst=10, mem_to_reg=10 -> S_FETCH.
- Retirement: instr_count increments by 1 on each transition into S_FETCH from a completing state. Wraps from 2^CNT_W-1 to 0.
- Wait counter: cleared on entering S_FETCH, S_MEM_RD or S_MEM_WR. Increments each cycle mem_ready=0 in those states.
- Timeout: if the counter reaches MEM_TIMEOUT (MEM_TIMEOUT>0) while mem_ready=0, bus_error is set and the next state is S_HALT. mem_ready=1 in that same cycle wins: normal completion, no error.
- S_HALT: halted=1, all strobes 0. Only reset exits.

Optional Feature:
IRQ_EN:
- Defined:
  - Adds ports irq (in, 1, level) and irq_ack (out, 1) and opcode 0D RETI.
  - At each retirement, if irq=1 and in_isr=0, the next state is S_IRQ instead of S_FETCH.
  - S_IRQ (1 cycle): pc_write=1, pc_source=11, reg_write=1, reg_dst=10, mem_to_reg=10, irq_ack=1; sets in_isr.
  - RETI uses the S_JMP strobes without link write and clears in_isr.
  - in_isr and irq_ack reset to 0.
- Undefined: no irq/irq_ack ports; 0D is illegal; pc_source never 11.

Test Plan:
- Reset release, mem_ready=1 always, ADD then HLT -> FETCH, DECODE, EXEC_R, WB_R (reg_write=1, reg_dst=01), FETCH, DECODE, HALT; instr_count=1, halted=1.
- LW with mem_ready low 3 cycles in S_MEM_RD -> mem_read held 4 cycles, then WB_LD with mem_to_reg=01; no bus_error.
- MEM_TIMEOUT=4, mem_ready stuck low in FETCH -> bus_error=1 and halted=1 after 4 wait cycles; only reset clears them.
- BEQ with zero_flag=1, then BNE with zero_flag=1 -> pc_write=1/pc_source=01 for the first, pc_write=0 for the second; count +2.
- Opcode 0x15 -> illegal_op pulses exactly 1 cycle, returns to FETCH, count unchanged; reset asserted mid-S_MEM_WR drops mem_write immediately.
- IRQ_EN: irq=1 during ADD retirement -> S_IRQ with pc_source=11, irq_ack 1 cycle; second irq ignored until RETI.

Source files
------------

// File: rtl/mc_control_unit_v2.sv
// Multi-cycle control FSM driving the datapath strobes, with memory wait states,
// bus timeout, HALT and a retired-instruction counter. `define IRQ_EN adds irq/irq_ack and RETI.
module mc_control_unit_v2 #(
    parameter int OPCODE_W    = 5,
    parameter int ALU_CTRL_W  = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  zero_flag,
    input  logic                  mem_ready,
`ifdef IRQ_EN
    input  logic                  irq,
    output logic                  irq_ack,
`endif
    output logic                  inst_read,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic [1:0]            pc_source,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic                  alu_src_b,
    output logic [1:0]            reg_dst,
    output logic [1:0]            mem_to_reg,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  halted,
    output logic                  bus_error,
    output logic                  illegal_op,
    output logic [CNT_W-1:0]      instr_count
);

    localparam logic [3:0] S_RESET  = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_EXEC_R = 4'd3;
    localparam logic [3:0] S_WB_R   = 4'd4;
    localparam logic [3:0] S_EXEC_I = 4'd5;
    localparam logic [3:0] S_WB_I   = 4'd6;
    localparam logic [3:0] S_ADDR   = 4'd7;
    localparam logic [3:0] S_MEM_RD = 4'd8;
    localparam logic [3:0] S_WB_LD  = 4'd9;
    localparam logic [3:0] S_MEM_WR = 4'd10;
    localparam logic [3:0] S_BR     = 4'd11;
    localparam logic [3:0] S_JMP    = 4'd12;
    localparam logic [3:0] S_HALT   = 4'd13;
`ifdef IRQ_EN
    localparam logic [3:0] S_IRQ    = 4'd14;
`endif

    localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(5'h00);
    localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(5'h01);
    localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(5'h02);
    localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(5'h03);
    localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(5'h04);
    localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(5'h05);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5'h06);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(5'h07);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(5'h08);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(5'h09);
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(5'h0A);
    localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(5'h0B);
    localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(5'h0C);
    localparam logic [OPCODE_W-1:0] OP_HLT  = OPCODE_W'(5'h1F);
`ifdef IRQ_EN
    localparam logic [OPCODE_W-1:0] OP_RETI = OPCODE_W'(5'h0D);
`endif

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR = ALU_CTRL_W'(4);

    // Counter only needs to reach MEM_TIMEOUT-1 before the timeout fires.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

    logic [3:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_err_q, bus_err_d;
    logic              retire;
    logic              wait_st;
    logic              tmo;
    logic              is_r;
`ifdef IRQ_EN
    logic              in_isr_q, in_isr_d;
`endif

    assign is_r = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                  (opcode == OP_AND) || (opcode == OP_OR)  ||
                  (opcode == OP_XOR);

    assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);

    // A completing handshake in the last allowed cycle wins over the timeout.
    assign tmo = (MEM_TIMEOUT > 0) && wait_st && !mem_ready &&
                 (wait_q == WAIT_LAST);

    // Next-state, retirement, wait counter and sticky error logic.
    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        bus_err_d = bus_err_q | tmo;
        wait_d    = (wait_st && !mem_ready && !tmo) ? wait_q + 1'b1 : '0;
`ifdef IRQ_EN
        in_isr_d  = in_isr_q;
`endif
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)  state_d = S_DECODE;
                else if (tmo)   state_d = S_HALT;
            end
            S_DECODE: begin
                if (is_r)                                   state_d = S_EXEC_R;
                else if (opcode == OP_ADDI)                 state_d = S_EXEC_I;
                else if (opcode == OP_LW || opcode == OP_SW) state_d = S_ADDR;
                else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = S_BR;
                else if (opcode == OP_JMP || opcode == OP_JAL) state_d = S_JMP;
`ifdef IRQ_EN
                else if (opcode == OP_RETI)                 state_d = S_JMP;
`endif
                else if (opcode == OP_HLT)                  state_d = S_HALT;
                else if (opcode == OP_NOP)                  retire  = 1'b1;
                else                                        state_d = S_FETCH;
            end
            S_EXEC_R: state_d = S_WB_R;
            S_WB_R:   retire  = 1'b1;
            S_EXEC_I: state_d = S_WB_I;
            S_WB_I:   retire  = 1'b1;
            S_ADDR:   state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)  state_d = S_WB_LD;
                else if (tmo)   state_d = S_HALT;
            end
            S_WB_LD:  retire  = 1'b1;
            S_MEM_WR: begin
                if (mem_ready)  retire  = 1'b1;
                else if (tmo)   state_d = S_HALT;
            end
            S_BR:     retire  = 1'b1;
            S_JMP: begin
                retire = 1'b1;
`ifdef IRQ_EN
                if (opcode == OP_RETI) in_isr_d = 1'b0;
`endif
            end
            S_HALT:   state_d = S_HALT;
`ifdef IRQ_EN
            S_IRQ: begin
                state_d  = S_FETCH;
                in_isr_d = 1'b1;
            end
`endif
            default:  state_d = S_RESET;
        endcase
        if (retire) begin
            state_d = S_FETCH;
`ifdef IRQ_EN
            if (irq && !in_isr_d) state_d = S_IRQ;
`endif
        end
        cnt_d = cnt_q + CNT_W'(retire);
    end

    // State and bookkeeping registers; reset aborts any instruction at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_RESET;
            wait_q    <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
`ifdef IRQ_EN
            in_isr_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
`ifdef IRQ_EN
            in_isr_q  <= in_isr_d;
`endif
        end
    end

    // Strobes decoded from the registered state (Moore, except FETCH/BR qualifiers).
    always_comb begin
        inst_read   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_source   = 2'b00;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        alu_src_b   = 1'b0;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;
        alu_control = ALU_ADD;
        illegal_op  = 1'b0;
`ifdef IRQ_EN
        irq_ack     = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                inst_read = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                illegal_op = !(is_r || opcode == OP_NOP || opcode == OP_ADDI ||
                               opcode == OP_LW || opcode == OP_SW ||
                               opcode == OP_BEQ || opcode == OP_BNE ||
                               opcode == OP_JMP || opcode == OP_JAL ||
`ifdef IRQ_EN
                               opcode == OP_RETI ||
`endif
                               opcode == OP_HLT);
            end
            S_EXEC_R: begin
                if (opcode == OP_SUB)      alu_control = ALU_SUB;
                else if (opcode == OP_AND) alu_control = ALU_AND;
                else if (opcode == OP_OR)  alu_control = ALU_OR;
                else if (opcode == OP_XOR) alu_control = ALU_XOR;
                else                       alu_control = ALU_ADD;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
            end
            S_EXEC_I: alu_src_b = 1'b1;
            S_WB_I:   reg_write = 1'b1;
            S_ADDR:   alu_src_b = 1'b1;
            S_MEM_RD: mem_read  = 1'b1;
            S_WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            S_MEM_WR: mem_write = 1'b1;
            S_BR: begin
                alu_control = ALU_SUB;
                pc_source   = 2'b01;
                pc_write    = (opcode == OP_BEQ) ? zero_flag : !zero_flag;
            end
            S_JMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                if (opcode == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
            end
`ifdef IRQ_EN
            S_IRQ: begin
                pc_write   = 1'b1;
                pc_source  = 2'b11;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                irq_ack    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign halted      = (state_q == S_HALT);
    assign bus_error   = bus_err_q;
    assign instr_count = cnt_q;

endmodule
